ex_mdu: RTL and testbench

//  Iterative multiply/divide unit in the EX stage, beside the ALU. Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO
//  and holds the architectural HI/LO registers. HI/LO feed the EX operand-A mux, and the ALU pass-A

---
 rtl/ex_mdu_pkg.sv | 24 ++
 rtl/ex_mdu_if.sv | 21 ++
 rtl/ex_mdu_div_step.sv | 27 ++
 rtl/ex_mdu.sv | 165 ++++++++++++++++
 tb/tb_ex_mdu.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
// The default operand width and the divide-by-zero quotient are defined here.
package mdu_pkg;

  localparam int MDU_XLEN = 32;
  localparam logic [MDU_XLEN-1:0] DIVZ_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_SIGN = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/ex_mdu_if.sv
// Issue and result bundle between the EX stage and the multiply/divide unit.
// The MDU takes the slave side. The EX stage or the testbench takes the master side.
interface ex_mdu_if import mdu_pkg::*; #(parameter int XLEN = MDU_XLEN);

  logic            i_start;
  logic [2:0]      i_op;
  logic [XLEN-1:0] i_a;
  logic [XLEN-1:0] i_b;
  logic            i_flush;
  logic [XLEN-1:0] o_hi;
  logic [XLEN-1:0] o_lo;
  logic            o_busy;
  logic            o_done;
  logic            o_stall;

  modport slave  (input  i_start, i_op, i_a, i_b, i_flush,
                  output o_hi, o_lo, o_busy, o_done, o_stall);
  modport master (output i_start, i_op, i_a, i_b, i_flush,
                  input  o_hi, o_lo, o_busy, o_done, o_stall);

endinterface

// File: rtl/ex_mdu_div_step.sv
// Performs one restoring-division iteration as pure combinational logic.
// It shifts the next dividend bit into the remainder, then does a trial subtract.
module mdu_div_step #(parameter int XLEN = 32) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quot,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quot
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  assign w_shift = {i_rem, i_quot[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, i_divisor};

  // The remainder stays below the divisor, so the top bit of w_diff is the borrow.
  always_comb begin
    o_rem  = w_shift[XLEN-1:0];
    o_quot = {i_quot[XLEN-2:0], 1'b0};
    if (!w_diff[XLEN]) begin
      o_rem  = w_diff[XLEN-1:0];
      o_quot = {i_quot[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// Define MDU_FAST_MULT_EN to replace the 33-cycle multiply with a single-cycle multiplier.
module ex_mdu import mdu_pkg::*; #(parameter int XLEN = MDU_XLEN) (
  input logic   clk,
  input logic   rst,
  ex_mdu_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  mdu_state_e        r_state;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opB;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic              r_negA;
  logic              r_negB;
  logic              r_isDiv;
  logic              r_busy;
  logic              r_done;

  logic              w_signedOp;
  logic              w_negA;
  logic              w_negB;
  logic [XLEN-1:0]   w_absA;
  logic [XLEN-1:0]   w_absB;
  logic [XLEN:0]     w_mulSum;
  logic [XLEN-1:0]   w_divRem;
  logic [XLEN-1:0]   w_divQuot;
  logic [2*XLEN-1:0] w_prodFix;
  logic              w_lastStep;
  logic              w_longOp;

  assign w_signedOp = (bus.i_op == MDU_MULT) || (bus.i_op == MDU_DIV);
  assign w_negA     = w_signedOp & bus.i_a[XLEN-1];
  assign w_negB     = w_signedOp & bus.i_b[XLEN-1];
  assign w_absA     = w_negA ? -bus.i_a : bus.i_a;
  assign w_absB     = w_negB ? -bus.i_b : bus.i_b;
  assign w_lastStep = (r_cnt == CW'(XLEN-1));

  // r_acc holds {partial product, remaining multiplier bits}. r_opB holds the multiplicand.
  assign w_mulSum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opB} : '0);
  assign w_prodFix = (r_negA ^ r_negB) ? -r_acc : r_acc;

  mdu_div_step #(.XLEN(XLEN)) u_divStep (
    .i_rem     (r_acc[2*XLEN-1:XLEN]),
    .i_quot    (r_acc[XLEN-1:0]),
    .i_divisor (r_opB),
    .o_rem     (w_divRem),
    .o_quot    (w_divQuot)
  );

`ifdef MDU_FAST_MULT_EN
  logic [2*XLEN-1:0] w_fastMag;
  logic [2*XLEN-1:0] w_fastProd;
  assign w_fastMag  = {{XLEN{1'b0}}, w_absA} * {{XLEN{1'b0}}, w_absB};
  assign w_fastProd = (w_negA ^ w_negB) ? -w_fastMag : w_fastMag;
  assign w_longOp   = bus.i_start & ((bus.i_op == MDU_DIV) || (bus.i_op == MDU_DIVU));
`else
  assign w_longOp   = bus.i_start & ~bus.i_op[2];
`endif

  assign bus.o_stall = r_busy | w_longOp;
  assign bus.o_busy  = r_busy;
  assign bus.o_done  = r_done;
  assign bus.o_hi    = r_hi;
  assign bus.o_lo    = r_lo;

  // Flush has priority over both an issue and an in-flight iteration. HI/LO survive a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opB   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_negA  <= 1'b0;
      r_negB  <= 1'b0;
      r_isDiv <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.i_flush) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.i_start) begin
              case (bus.i_op)
                MDU_MULT, MDU_MULTU: begin
`ifdef MDU_FAST_MULT_EN
                  {r_hi, r_lo} <= w_fastProd;
                  r_done       <= 1'b1;
`else
                  r_state <= ST_MUL;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_acc   <= {{XLEN{1'b0}}, w_absB};
                  r_opB   <= w_absA;
                  r_negA  <= w_negA;
                  r_negB  <= w_negB;
                  r_isDiv <= 1'b0;
`endif
                end
                MDU_DIV, MDU_DIVU: begin
                  r_state <= ST_DIV;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_acc   <= {{XLEN{1'b0}}, w_absA};
                  r_opB   <= w_absB;
                  r_negA  <= w_negA;
                  r_negB  <= w_negB;
                  r_isDiv <= 1'b1;
                end
                MDU_MTHI: r_hi <= bus.i_a;
                MDU_MTLO: r_lo <= bus.i_a;
                default: ;
              endcase
            end
          end
          ST_MUL: begin
            r_acc <= {w_mulSum, r_acc[XLEN-1:1]};
            if (w_lastStep) begin
              r_state <= ST_SIGN;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_DIV: begin
            r_acc <= {w_divRem, w_divQuot};
            if (w_lastStep) begin
              r_state <= ST_SIGN;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_SIGN: begin
            // The remainder takes the dividend's sign, which also yields hi=a on divide-by-zero.
            if (r_isDiv) begin
              r_hi <= r_negA ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
              if (r_opB == '0)
                r_lo <= DIVZ_QUOT;
              else
                r_lo <= (r_negA ^ r_negB) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
            end else begin
              {r_hi, r_lo} <= w_prodFix;
            end
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed testbench for ex_mdu. Expected values are worked out by hand from the operand pairs.
// It follows the fast-multiply variant when MDU_FAST_MULT_EN is defined.
module tb_ex_mdu;
  import mdu_pkg::*;

`ifdef MDU_FAST_MULT_EN
  localparam int   MUL_LAT   = 0;
  localparam logic MUL_STALL = 1'b0;
`else
  localparam int   MUL_LAT   = 33;
  localparam logic MUL_STALL = 1'b1;
`endif

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;
  int   cycles;
  int   donePulses;

  ex_mdu_if #(.XLEN(32)) bus();

  ex_mdu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    else
      passCount++;
  endtask

  // Issue one op: check the combinational stall before the edge, then drop start.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic expStall);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    #1;
    checkOutput("stall_at_issue", 64'(bus.o_stall), 64'(expStall));
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
  endtask

  task automatic waitDone(input int maxCycles, output int n);
    n = 0;
    while (!bus.o_done && n < maxCycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.o_done) checkOutput("done_timeout", 64'(bus.o_done), 64'd1);
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic expStall, input int expLat,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    applyStimulus(op, a, b, expStall);
    waitDone(60, cycles);
    checkOutput({tag, "_latency"}, 64'(cycles), 64'(expLat));
    checkOutput({tag, "_hi"}, 64'(bus.o_hi), 64'(expHi));
    checkOutput({tag, "_lo"}, 64'(bus.o_lo), 64'(expLo));
    checkOutput({tag, "_busy_end"}, 64'(bus.o_busy), 64'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse"}, 64'(bus.o_done), 64'd0);
  endtask

  initial begin
    checkCount    = 0;
    passCount     = 0;
    rst           = 1'b1;
    bus.i_start   = 1'b0;
    bus.i_op      = 3'd7;
    bus.i_a       = '0;
    bus.i_b       = '0;
    bus.i_flush   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_hi", 64'(bus.o_hi), 64'd0);
    checkOutput("reset_lo", 64'(bus.o_lo), 64'd0);
    checkOutput("reset_busy", 64'(bus.o_busy), 64'd0);
    checkOutput("reset_done", 64'(bus.o_done), 64'd0);
    checkOutput("reset_stall", 64'(bus.o_stall), 64'd0);

    runOp("mult_m3x7", MDU_MULT, 32'hFFFF_FFFD, 32'd7, MUL_STALL, MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    runOp("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 1'b1, 33, 32'd2, 32'd14);
    runOp("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("div_5_0", MDU_DIV, 32'd5, 32'd0, 1'b1, 33, 32'd5, 32'hFFFF_FFFF);
    runOp("div_min_m1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 32'd0, 32'h8000_0000);
    runOp("multu_max_2", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, MUL_STALL, MUL_LAT, 32'd1, 32'hFFFF_FFFE);

    // Load known HI/LO, start a divide, try a second issue while busy, then flush it.
    runOp("div_seed", MDU_DIVU, 32'd50, 32'd8, 1'b1, 33, 32'd2, 32'd6);
    applyStimulus(MDU_DIVU, 32'd1000, 32'd3, 1'b1);
    checkOutput("flush_busy_started", 64'(bus.o_busy), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    bus.i_start = 1'b1;
    bus.i_op    = MDU_MTHI;
    bus.i_a     = 32'h0000_1234;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("flush_busy_before", 64'(bus.o_busy), 64'd1);
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    checkOutput("flush_busy_after", 64'(bus.o_busy), 64'd0);
    donePulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_done) donePulses++;
      @(posedge clk);
      #1;
    end
    checkOutput("flush_no_done", 64'(donePulses), 64'd0);
    checkOutput("flush_hi_kept", 64'(bus.o_hi), 64'd2);
    checkOutput("flush_lo_kept", 64'(bus.o_lo), 64'd6);

    applyStimulus(MDU_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
    checkOutput("mthi_hi", 64'(bus.o_hi), 64'hDEAD_BEEF);
    checkOutput("mthi_busy", 64'(bus.o_busy), 64'd0);
    checkOutput("mthi_done", 64'(bus.o_done), 64'd0);
    applyStimulus(MDU_MTLO, 32'd1, 32'd0, 1'b0);
    checkOutput("mtlo_lo", 64'(bus.o_lo), 64'd1);
    checkOutput("mtlo_hi_kept", 64'(bus.o_hi), 64'hDEAD_BEEF);

    applyStimulus(3'd6, 32'h1111_1111, 32'h2222_2222, 1'b0);
    checkOutput("nop_hi", 64'(bus.o_hi), 64'hDEAD_BEEF);
    checkOutput("nop_lo", 64'(bus.o_lo), 64'd1);
    checkOutput("nop_busy", 64'(bus.o_busy), 64'd0);

    bus.i_flush = 1'b1;
    applyStimulus(MDU_MTHI, 32'h0000_0055, 32'd0, 1'b0);
    bus.i_flush = 1'b0;
    checkOutput("flush_beats_start", 64'(bus.o_hi), 64'hDEAD_BEEF);

    // Reset is asynchronous, so check it between edges.
    applyStimulus(MDU_MULT, 32'd5, 32'd6, MUL_STALL);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    checkOutput("rst_mid_hi", 64'(bus.o_hi), 64'd0);
    checkOutput("rst_mid_lo", 64'(bus.o_lo), 64'd0);
    checkOutput("rst_mid_busy", 64'(bus.o_busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
